// File: rtl/tblink_rpc_invoke_arb.sv
// Shares one RPC invoke channel among N_REQ BFM requesters: round-robin request
// arbitration into a single output slot, with tag-routed responses for blocking invokes.
module tblink_rpc_invoke_arb #(
    parameter int N_REQ     = 4,
    parameter int METHOD_W  = 16,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4,
    parameter int TAG_W     = $clog2(N_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_blocking,
    input  logic [N_REQ*METHOD_W-1:0]      req_method,
    input  logic [N_REQ*DATA_W-1:0]        req_data,
    output logic                           ch_req_valid,
    input  logic                           ch_req_ready,
    output logic [METHOD_W-1:0]            ch_req_method,
    output logic                           ch_req_blocking,
    output logic [TAG_W-1:0]               ch_req_tag,
    output logic [DATA_W-1:0]              ch_req_data,
    input  logic                           ch_rsp_valid,
    output logic                           ch_rsp_ready,
    input  logic [TAG_W-1:0]               ch_rsp_tag,
    input  logic [DATA_W-1:0]              ch_rsp_data,
    output logic [N_REQ-1:0]               rsp_valid,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [N_REQ-1:0]               busy,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err_unexp_rsp
);
    localparam int CNT_W = $clog2(MAX_OUTST+1);
    localparam int TAG_N = 1 << TAG_W;

    function automatic logic [TAG_W-1:0] next_idx(input logic [TAG_W-1:0] idx);
        next_idx = (int'(idx) == N_REQ-1) ? '0 : idx + TAG_W'(1);
    endfunction

    logic                vld_q, vld_d;
    logic [METHOD_W-1:0] method_q;
    logic                blk_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   data_q;
    logic [N_REQ-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [TAG_W-1:0]    rr_q, rr_d;

    logic [N_REQ-1:0]    elig;
    logic                room, slot_free, gnt_vld, cap, cap_blk;
    logic [TAG_W-1:0]    gnt_idx, idx;
    logic [TAG_N-1:0]    busy_ext, rdy_ext;
    logic                rsp_hit, rsp_rel;

    assign room      = (cnt_q < CNT_W'(MAX_OUTST));
    assign slot_free = ~vld_q | ch_req_ready;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] & ~busy_q[i] & (~req_blocking[i] | room);
        end
    end

    // Search from the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
            idx = next_idx(idx);
        end
    end

    assign cap     = slot_free & gnt_vld & ~reset;
    assign cap_blk = cap & req_blocking[gnt_idx];

    always_comb begin
        req_ready = '0;
        if (cap) req_ready[gnt_idx] = 1'b1;
    end

    // Pad to the full tag space so out-of-range tags read as not busy.
    always_comb begin
        busy_ext = '0;
        rdy_ext  = '0;
        busy_ext[N_REQ-1:0] = busy_q;
        rdy_ext[N_REQ-1:0]  = rsp_ready;
    end

    assign rsp_hit      = busy_ext[ch_rsp_tag];
    assign ch_rsp_ready = rsp_hit ? rdy_ext[ch_rsp_tag] : 1'b1;
    assign rsp_rel      = ch_rsp_valid & rsp_hit & ch_rsp_ready;
    assign rsp_data     = ch_rsp_data;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = ch_rsp_valid & rsp_hit & (ch_rsp_tag == TAG_W'(i));
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (cap_blk && gnt_idx == TAG_W'(i)) busy_d[i] = 1'b1;
            if (rsp_rel && ch_rsp_tag == TAG_W'(i)) busy_d[i] = 1'b0;
        end
        cnt_d = cnt_q;
        case ({cap_blk, rsp_rel})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        vld_d = cap ? 1'b1 : (ch_req_ready ? 1'b0 : vld_q);
        rr_d  = cap ? next_idx(gnt_idx) : rr_q;
        err_d = ch_rsp_valid & ~rsp_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            rr_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            rr_q   <= rr_d;
        end
    end

    // Payload slot: loaded on capture only, otherwise held for the bridge.
    always_ff @(posedge clock) begin
        if (cap) begin
            method_q <= req_method[gnt_idx*METHOD_W +: METHOD_W];
            data_q   <= req_data[gnt_idx*DATA_W +: DATA_W];
            blk_q    <= req_blocking[gnt_idx];
            tag_q    <= gnt_idx;
        end
    end

    assign ch_req_valid    = vld_q;
    assign ch_req_method   = method_q;
    assign ch_req_blocking = blk_q;
    assign ch_req_tag      = tag_q;
    assign ch_req_data     = data_q;
    assign busy            = busy_q;
    assign outst_cnt       = cnt_q;
    assign err_unexp_rsp   = err_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_arb.sv
// Bench for tblink_rpc_invoke_arb: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_tblink_rpc_invoke_arb;
    localparam int N  = 4;
    localparam int MW = 16;
    localparam int DW = 64;
    localparam int MO = 2;
    localparam int TW = $clog2(N);
    localparam int CW = $clog2(MO+1);

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, req_blocking;
    logic [N*MW-1:0] req_method;
    logic [N*DW-1:0] req_data;
    logic            ch_req_valid, ch_req_ready, ch_req_blocking;
    logic [MW-1:0]   ch_req_method;
    logic [TW-1:0]   ch_req_tag;
    logic [DW-1:0]   ch_req_data;
    logic            ch_rsp_valid, ch_rsp_ready;
    logic [TW-1:0]   ch_rsp_tag;
    logic [DW-1:0]   ch_rsp_data;
    logic [N-1:0]    rsp_valid, rsp_ready, busy;
    logic [DW-1:0]   rsp_data;
    logic [CW-1:0]   outst_cnt;
    logic            err_unexp_rsp;

    tblink_rpc_invoke_arb #(.N_REQ(N), .METHOD_W(MW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_blocking(req_blocking),
        .req_method(req_method), .req_data(req_data),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_method(ch_req_method), .ch_req_blocking(ch_req_blocking),
        .ch_req_tag(ch_req_tag), .ch_req_data(ch_req_data),
        .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready),
        .ch_rsp_tag(ch_rsp_tag), .ch_rsp_data(ch_rsp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .outst_cnt(outst_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state (valid once a reset has been applied)
    bit            m_known = 1'b0;
    bit            m_vld, m_blk, m_err;
    int            m_tag, m_cnt, m_rr;
    logic [MW-1:0] m_meth;
    logic [DW-1:0] m_data;
    bit            m_busy [N];
    logic [N-1:0]  last_acc = '0;

    task automatic cycle();
        bit            free, cap, hit, rst_s;
        bit            n_vld, n_blk, n_err;
        int            g, rt, n_tag, n_cnt, n_rr;
        logic [MW-1:0] n_meth;
        logic [DW-1:0] n_data;
        bit            n_busy [N];
        logic [N-1:0]  bv, exp_rdy, exp_rv;
        logic          exp_crr;
        @(negedge clock);
        for (int i = 0; i < N; i++) bv[i] = m_busy[i];
        if (m_known) begin
            chk("ch_req_valid", ch_req_valid, m_vld);
            if (m_vld) begin
                chk("ch_req_tag", ch_req_tag, m_tag);
                chk("ch_req_method", ch_req_method, m_meth);
                chk("ch_req_blocking", ch_req_blocking, m_blk);
                chk("ch_req_data", ch_req_data, m_data);
            end
            chk("busy", busy, bv);
            chk("outst_cnt", outst_cnt, m_cnt);
            chk("err_unexp_rsp", err_unexp_rsp, m_err);
        end
        free = !m_vld || ch_req_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int ix;
            ix = (m_rr + k) % N;
            if (g < 0 && req_valid[ix] && !m_busy[ix] && (!req_blocking[ix] || m_cnt < MO)) g = ix;
        end
        cap = !reset && free && (g >= 0);
        exp_rdy = '0;
        if (cap) exp_rdy[g] = 1'b1;
        rt  = int'(ch_rsp_tag);
        hit = (rt < N) ? m_busy[rt] : 1'b0;
        exp_rv = '0;
        if (hit && ch_rsp_valid) exp_rv[rt] = 1'b1;
        exp_crr = hit ? rsp_ready[rt] : 1'b1;
        if (m_known) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("ch_rsp_ready", ch_rsp_ready, exp_crr);
            if (exp_rv != '0) chk("rsp_data", rsp_data, ch_rsp_data);
        end
        last_acc = req_ready;
        n_vld = m_vld; n_tag = m_tag; n_meth = m_meth; n_blk = m_blk; n_data = m_data;
        n_busy = m_busy; n_cnt = m_cnt; n_rr = m_rr;
        if (cap) begin
            n_vld  = 1'b1;
            n_tag  = g;
            n_meth = req_method[g*MW +: MW];
            n_data = req_data[g*DW +: DW];
            n_blk  = req_blocking[g];
            n_rr   = (g + 1) % N;
            if (req_blocking[g]) begin
                n_busy[g] = 1'b1;
                n_cnt++;
            end
        end else if (ch_req_ready) begin
            n_vld = 1'b0;
        end
        if (hit && ch_rsp_valid && rsp_ready[rt]) begin
            n_busy[rt] = 1'b0;
            n_cnt--;
        end
        n_err = ch_rsp_valid && !hit;
        rst_s = reset;
        if (rst_s) begin
            n_vld = 1'b0; n_cnt = 0; n_err = 1'b0; n_rr = 0;
            for (int i = 0; i < N; i++) n_busy[i] = 1'b0;
        end
        @(posedge clock);
        #1;
        m_vld = n_vld; m_tag = n_tag; m_meth = n_meth; m_blk = n_blk; m_data = n_data;
        m_busy = n_busy; m_cnt = n_cnt; m_rr = n_rr; m_err = n_err;
        if (rst_s) m_known = 1'b1;
    endtask

    task automatic set_req(input int i, input bit v, input bit b, input logic [MW-1:0] m,
                           input logic [DW-1:0] d);
        req_valid[i] = v;
        req_blocking[i] = b;
        req_method[i*MW +: MW] = m;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        ch_rsp_valid = 1'b0;
        ch_req_ready = 1'b1;
        rsp_ready = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int blist [$];

    initial begin
        reset = 1'b1;
        req_valid = '0; req_blocking = '0; req_method = '0; req_data = '0;
        ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; ch_rsp_tag = '0; ch_rsp_data = '0;
        rsp_ready = '0;
        do_reset();

        // Four non-blocking requesters, bridge always ready
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, MW'(16'h100 + i), DW'(i));
        cycle();
        chk("first_vld", ch_req_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("rr_tag_seq", ch_req_tag, exp_seq[k]);
            chk("rr_outst0", outst_cnt, 0);
            cycle();
        end

        // Single blocking invoke and its response
        do_reset();
        set_req(2, 1'b1, 1'b1, 16'h0012, 64'hDEAD_BEEF);
        cycle();
        chk("blk_tag", ch_req_tag, 2);
        chk("blk_method", ch_req_method, 16'h0012);
        chk("blk_data", ch_req_data, 64'hDEAD_BEEF);
        chk("blk_busy", busy, 4'b0100);
        chk("blk_cnt", outst_cnt, 1);
        cycle();
        chk("no_regrant", ch_req_valid, 1'b0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        ch_rsp_valid = 1'b1; ch_rsp_tag = 2'd2; ch_rsp_data = 64'h55; rsp_ready = 4'b0100;
        #1;
        chk("rsp2_valid", rsp_valid, 4'b0100);
        chk("rsp2_data", rsp_data, 64'h55);
        chk("rsp2_busy_held", busy, 4'b0100);
        cycle();
        ch_rsp_valid = 1'b0;
        chk("rsp2_busy_clr", busy, 4'b0000);
        chk("rsp2_cnt", outst_cnt, 0);

        // Outstanding cap of MO=2 with all requesters blocking
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, MW'(16'h200 + i), DW'(64'hA0 + i));
        cycle();
        chk("cap_tag0", ch_req_tag, 0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("cap_tag1", ch_req_tag, 1);
        chk("cap_cnt2", outst_cnt, 2);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("cap_stall", ch_req_valid, 1'b0);
        cycle();
        chk("cap_stall2", ch_req_valid, 1'b0);
        ch_rsp_valid = 1'b1; ch_rsp_tag = 2'd0; ch_rsp_data = 64'h77; rsp_ready = 4'b1111;
        cycle();
        ch_rsp_valid = 1'b0;
        chk("cap_rel_cnt", outst_cnt, 1);
        cycle();
        chk("cap_tag2", ch_req_tag, 2);
        chk("cap_cnt_back", outst_cnt, 2);
        set_req(2, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b1, 1'b0, 16'h0303, 64'h3);
        cycle();
        chk("cap_nb_tag3", ch_req_tag, 3);
        chk("cap_nb_cnt", outst_cnt, 2);
        set_req(3, 1'b0, 1'b0, '0, '0);

        // Channel back-pressure with requesters pending
        do_reset();
        ch_req_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, MW'(16'h400 + i), DW'(64'hB0 + i));
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_tag", ch_req_tag, 0);
            chk("hold_data", ch_req_data, 64'hB0);
            cycle();
        end
        ch_req_ready = 1'b1;
        for (int k = 1; k < N; k++) begin
            cycle();
            chk("resume_tag", ch_req_tag, k);
            set_req(k, 1'b0, 1'b0, '0, '0);
        end

        // Response for a requester that is not busy
        ch_rsp_valid = 1'b1; ch_rsp_tag = 2'd1; ch_rsp_data = 64'h99; rsp_ready = '0;
        #1;
        chk("unexp_ready", ch_rsp_ready, 1'b1);
        chk("unexp_no_rsp", rsp_valid, 4'b0000);
        cycle();
        ch_rsp_valid = 1'b0;
        chk("unexp_err", err_unexp_rsp, 1'b1);
        cycle();
        chk("unexp_err_pulse", err_unexp_rsp, 1'b0);

        // Simultaneous blocking capture and release, then reset during a hold
        do_reset();
        set_req(0, 1'b1, 1'b1, 16'h0500, 64'hC0);
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("same_cnt1", outst_cnt, 1);
        set_req(3, 1'b1, 1'b1, 16'h0503, 64'hC3);
        ch_rsp_valid = 1'b1; ch_rsp_tag = 2'd0; ch_rsp_data = 64'h11; rsp_ready = 4'b0001;
        cycle();
        ch_rsp_valid = 1'b0;
        chk("same_cnt_kept", outst_cnt, 1);
        chk("same_busy", busy, 4'b1000);
        chk("same_tag3", ch_req_tag, 3);
        set_req(3, 1'b0, 1'b0, '0, '0);
        ch_req_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, 16'h0511, 64'hC1);
        cycle();
        chk("midhold_vld", ch_req_valid, 1'b1);
        chk("midhold_tag", ch_req_tag, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("rst_vld", ch_req_valid, 1'b0);
        chk("rst_busy", busy, 4'b0000);
        chk("rst_cnt", outst_cnt, 0);
        ch_req_ready = 1'b1;
        ch_rsp_valid = 1'b1; ch_rsp_tag = 2'd3; ch_rsp_data = 64'h22; rsp_ready = 4'b1111;
        cycle();
        ch_rsp_valid = 1'b0;
        chk("stale_err", err_unexp_rsp, 1'b1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_acc[i])
                    set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                            MW'($urandom), {$urandom, $urandom});
            end
            ch_req_ready = $urandom_range(0, 9) < 7;
            ch_rsp_valid = $urandom_range(0, 9) < 4;
            blist = {};
            for (int i = 0; i < N; i++) if (m_busy[i]) blist.push_back(i);
            if (blist.size() > 0 && $urandom_range(0, 4) != 0)
                ch_rsp_tag = TW'(blist[$urandom_range(0, blist.size() - 1)]);
            else
                ch_rsp_tag = TW'($urandom_range(0, N - 1));
            ch_rsp_data = {$urandom, $urandom};
            rsp_ready = N'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
